// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the instruction-memory write port and the pipeline
// enable. Single-byte commands arrive from the debug UART: 'L' loads a
// little-endian word stream into instruction memory, 'R' runs the pipeline
// until a halt, and 'S' advances it by one cycle. All outputs are registered.
module imem_load_ctrl #(
  parameter int                 INST_SZ     = 32,
  parameter int                 PC_SZ       = 32,
  parameter int                 MEM_DEPTH_W = 8,
  parameter logic [INST_SZ-1:0] HALT_WORD   = {INST_SZ{1'b1}}
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_halt,
  output logic                   o_write,
  output logic [PC_SZ-1:0]       o_addr,
  output logic [INST_SZ-1:0]     o_instruction,
  output logic                   o_pipe_enable,
  output logic                   o_pipe_reset,
  output logic                   o_loading,
  output logic                   o_halted,
  output logic                   o_overflow,
  output logic [MEM_DEPTH_W:0]   o_word_count
);

  localparam int BYTES  = INST_SZ / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STEP} state_e;

  state_e                 state_q, state_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [MEM_DEPTH_W-1:0] widx_q, widx_d;
  logic [INST_SZ-1:0]     asm_q, asm_d;
  // High during the write cycle of the word that terminates the load
  // (either HALT_WORD or the last memory slot).
  logic                   end_q, end_d;

  logic                   write_q, write_d;
  logic [PC_SZ-1:0]       addr_q, addr_d;
  logic [INST_SZ-1:0]     instr_q, instr_d;
  logic                   pipe_en_q, pipe_en_d;
  logic                   pipe_rst_q, pipe_rst_d;
  logic                   loading_q, loading_d;
  logic                   halted_q, halted_d;
  logic                   overflow_q, overflow_d;
  logic [MEM_DEPTH_W:0]   wcount_q, wcount_d;

  // Word as it will look once the current byte is shifted in at the top;
  // after BYTES shifts the first byte sits in [7:0].
  logic [INST_SZ-1:0]     asm_shift;
  assign asm_shift = {i_rx_data, asm_q[INST_SZ-1:8]};

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    widx_d     = widx_q;
    asm_d      = asm_q;
    end_d      = end_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pipe_en_d  = 1'b0;
    pipe_rst_d = 1'b0;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    wcount_d   = wcount_q;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d    = LOAD;
            pipe_rst_d = 1'b1;
            bcnt_d     = '0;
            widx_d     = '0;
            asm_d      = '0;
            end_d      = 1'b0;
            wcount_d   = '0;
            halted_d   = 1'b0;
            overflow_d = 1'b0;
          end else if (i_rx_data == CMD_RUN && !halted_q) begin
            state_d   = RUN;
            pipe_en_d = 1'b1;
          end else if (i_rx_data == CMD_STEP && !halted_q) begin
            state_d   = STEP;
            pipe_en_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (end_q) begin
          // Final write is on the bus now; bytes in this cycle are dropped.
          state_d = IDLE;
          end_d   = 1'b0;
          if (instr_q != HALT_WORD) overflow_d = 1'b1;
        end else if (i_rx_valid) begin
          asm_d = asm_shift;
          if (bcnt_q == BCNT_W'(BYTES - 1)) begin
            bcnt_d   = '0;
            write_d  = 1'b1;
            instr_d  = asm_shift;
            addr_d   = PC_SZ'({widx_q, 2'b00});
            widx_d   = widx_q + MEM_DEPTH_W'(1);
            wcount_d = wcount_q + (MEM_DEPTH_W + 1)'(1);
            if (asm_shift == HALT_WORD || widx_q == {MEM_DEPTH_W{1'b1}})
              end_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      RUN: begin
        if (i_halt) begin
          state_d  = IDLE;
          halted_d = 1'b1;
        end else begin
          pipe_en_d = 1'b1;
        end
      end
      STEP: begin
        state_d = IDLE;
        if (i_halt) halted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    loading_d = (state_d == LOAD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      widx_q     <= '0;
      asm_q      <= '0;
      end_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      pipe_en_q  <= 1'b0;
      pipe_rst_q <= 1'b0;
      loading_q  <= 1'b0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      widx_q     <= widx_d;
      asm_q      <= asm_d;
      end_q      <= end_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pipe_en_q  <= pipe_en_d;
      pipe_rst_q <= pipe_rst_d;
      loading_q  <= loading_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      wcount_q   <= wcount_d;
    end
  end

  assign o_write       = write_q;
  assign o_addr        = addr_q;
  assign o_instruction = instr_q;
  assign o_pipe_enable = pipe_en_q;
  assign o_pipe_reset  = pipe_rst_q;
  assign o_loading     = loading_q;
  assign o_halted      = halted_q;
  assign o_overflow    = overflow_q;
  assign o_word_count  = wcount_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: directed command sequence with random word
// data and random inter-byte gaps; expected writes come from splitting the
// byte stream into little-endian words.
module tb_imem_load_ctrl;

  localparam int          MW   = 8;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        halt = 1'b0;
  logic        o_write;
  logic [31:0] o_addr;
  logic [31:0] o_instruction;
  logic        o_pipe_enable;
  logic        o_pipe_reset;
  logic        o_loading;
  logic        o_halted;
  logic        o_overflow;
  logic [MW:0] o_word_count;

  always #5 clk = ~clk;

  imem_load_ctrl #(
    .INST_SZ(32), .PC_SZ(32), .MEM_DEPTH_W(MW), .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_halt(halt), .o_write(o_write), .o_addr(o_addr),
    .o_instruction(o_instruction), .o_pipe_enable(o_pipe_enable),
    .o_pipe_reset(o_pipe_reset), .o_loading(o_loading), .o_halted(o_halted),
    .o_overflow(o_overflow), .o_word_count(o_word_count)
  );

  int checks = 0;
  int errors = 0;

  // Observation of the DUT, sampled on the falling edge.
  logic [63:0] wr_q[$];
  int          en_cycles = 0, en_pulses = 0, rst_cycles = 0, viol = 0;
  logic        en_prev = 1'b0;

  always @(negedge clk) begin
    if (o_write) wr_q.push_back({o_addr, o_instruction});
    if (o_pipe_enable) en_cycles++;
    if (o_pipe_enable && !en_prev) en_pulses++;
    en_prev = o_pipe_enable;
    if (o_pipe_reset) rst_cycles++;
    if ((o_write && o_pipe_enable) || (o_pipe_enable && (o_loading || o_pipe_reset))
        || (o_write && !o_loading))
      viol++;
  end

  task automatic clear_mon();
    wr_q.delete();
    en_cycles  = 0;
    en_pulses  = 0;
    rst_cycles = 0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the byte stream after 'L' is cut into little-endian
  // words; writing stops after HALT or after the last memory slot.
  logic [7:0]  stream[$];
  logic [63:0] exp_q[$];
  bit          exp_ovf;

  task automatic build_expect();
    logic [31:0] w;
    int idx;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i + 3 < stream.size(); i += 4) begin
      w   = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
      idx = i / 4;
      exp_q.push_back({32'(idx * 4), w});
      if (w == HALT) break;
      if (idx == (1 << MW) - 1) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  task automatic gen_words(input int n, input bit end_halt);
    logic [31:0] w;
    stream.delete();
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
    end
    if (end_halt) for (int b = 0; b < 4; b++) stream.push_back(8'hFF);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_load(input int gapmax);
    drive_byte(8'h4C);
    foreach (stream[k]) begin
      drive_byte(stream[k]);
      idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic finish_load(input string tag);
    int t = 0;
    while (o_loading && t < 40) begin
      @(negedge clk);
      t++;
    end
    #1;
    check({tag, "_done"}, o_loading, 1'b0);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_wr%0d", tag, k), wr_q[k], exp_q[k]);
    check({tag, "_cnt"}, o_word_count, exp_q.size());
    check({tag, "_ovf"}, o_overflow, exp_ovf);
    check({tag, "_prst"}, rst_cycles, 1);
    check({tag, "_en"}, en_cycles, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {o_write, o_pipe_enable, o_pipe_reset, o_loading, o_halted, o_overflow}, 6'b0);
    check({tag, "_addr"}, o_addr, 32'h0);
    check({tag, "_instr"}, o_instruction, 32'h0);
    check({tag, "_cnt"}, o_word_count, 0);
  endtask

  initial begin
    int n;
    // Reset
    idle(3);
    rst = 1'b0;
    @(negedge clk); #1;
    check_zero("reset");

    // Non-command bytes in IDLE
    clear_mon();
    drive_byte(8'h00); idle(1);
    drive_byte(8'h41); idle(3); #1;
    check_zero("idle_junk");
    check("idle_junk_wr", wr_q.size(), 0);

    // Directed load from the test plan
    clear_mon();
    stream = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    build_expect();
    send_load(2);
    finish_load("load1");

    // RUN until halt after n cycles
    n = $urandom_range(1, 20);
    clear_mon();
    drive_byte(8'h52);
    idle(n - 1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    idle(3); #1;
    check("run_en_cycles", en_cycles, n);
    check("run_en_pulses", en_pulses, 1);
    check("run_halted", o_halted, 1'b1);
    drive_byte(8'h52); idle(3);
    drive_byte(8'h53); idle(3); #1;
    check("run_ignored_en", en_cycles, n);
    check("run_ignored_halted", o_halted, 1'b1);

    // Reload, then three single steps
    clear_mon();
    gen_words(3, 1'b1);
    build_expect();
    send_load(2);
    finish_load("load2");
    check("load2_halted_clr", o_halted, 1'b0);
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      drive_byte(8'h53);
      idle(2);
    end
    #1;
    check("step_cycles", en_cycles, 3);
    check("step_pulses", en_pulses, 3);
    check("step_writes", wr_q.size(), 0);
    check("step_halted", o_halted, 1'b0);
    drive_byte(8'h53);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    idle(2); #1;
    check("step_halt_flag", o_halted, 1'b1);
    drive_byte(8'h53); idle(3); #1;
    check("step_halt_ignored", en_cycles, 4);

    // Reset in the middle of a word
    clear_mon();
    drive_byte(8'h4C);
    drive_byte(8'hA5); idle(1);
    drive_byte(8'h5A); idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    check("midrst_wr", wr_q.size(), 0);
    clear_mon();
    gen_words(1, 1'b1);
    build_expect();
    send_load(2);
    finish_load("load3");

    // Back-to-back bytes: each word's successor lands in the write cycle
    clear_mon();
    gen_words(3, 1'b1);
    build_expect();
    send_load(0);
    finish_load("b2b");

    // Fill the whole memory without HALT, followed by stray bytes
    clear_mon();
    gen_words(1 << MW, 1'b0);
    for (int k = 0; k < 4; k++) stream.push_back(8'($urandom_range(0, 8'h3F)));
    build_expect();
    send_load(1);
    idle(4);
    finish_load("ovf");

    check("invariants", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller that owns the instruction-fetch stage's memory write port and the pipeline enable. It receives a byte stream (from the debug UART receiver), decodes single-byte commands, assembles little-endian 32-bit words and writes them sequentially into instruction memory. It then releases the pipeline either free-running until a halt or one cycle at a time. It sits between the UART RX FIFO and the IF stage (instruction write data/enable, PC stall/enable, pipeline reset).

Parameters:
INST_SZ, 32, instruction word width (multiple of 8)
PC_SZ, 32, byte-address width of o_addr
MEM_DEPTH_W, 8, log2 of instruction-memory depth in words
HALT_WORD, 32'hFFFFFFFF, end-of-program marker word

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_rx_data  input  8  received byte
i_rx_valid  input  1  byte valid; one-cycle pulse per byte, consumed in that cycle
i_halt  input  1  halt instruction reached write-back
o_write  output  1  instruction-memory write strobe
o_addr  output  PC_SZ  byte address of the write (word_index*4)
o_instruction  output  INST_SZ  word to write
o_pipe_enable  output  1  PC/pipeline enable (1 = advance)
o_pipe_reset  output  1  one-cycle pipeline/PC reset pulse
o_loading  output  1  high while in LOAD
o_halted  output  1  sticky halt flag
o_overflow  output  1  sticky: memory filled before HALT_WORD
o_word_count  output  MEM_DEPTH_W+1  words written since last load

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge): state IDLE; all outputs 0; byte counter, word index and assembly register cleared. Reset mid-LOAD abandons the partial word; no write is issued.
- States: IDLE, LOAD, RUN, STEP. All outputs are registered.
- IDLE: with i_rx_valid=1, byte 0x4C ('L') -> LOAD; 0x52 ('R') -> RUN; 0x53 ('S') -> STEP. Any other byte is ignored. 'R' and 'S' are ignored while o_halted=1.
- Entering LOAD: o_pipe_reset=1 for exactly the next cycle. Word index, byte counter, o_word_count, o_halted and o_overflow are cleared.
- LOAD: each valid byte is shifted into the assembly register; the first byte lands in [7:0], the fourth in [31:24]. Command values carry no meaning in LOAD.
- The cycle after the 4th byte is accepted: o_write=1 for one cycle, o_instruction=assembled word, o_addr={word_index,2'b00} zero-extended to PC_SZ. Word index and o_word_count then increment.
- A byte arriving during the write cycle is accepted normally; there is no backpressure.
- If the written word equals HALT_WORD, it is still written, and the state returns to IDLE the cycle after the write.
- If the word at index 2^MEM_DEPTH_W-1 is written and is not HALT_WORD: set o_overflow, return to IDLE, and ignore further bytes of that stream.
- o_loading is high during every LOAD cycle, including the final write cycle.
- RUN: o_pipe_enable=1 starting the cycle after 'R' is accepted. When i_halt=1 is sampled, o_pipe_enable=0 from the next cycle, o_halted=1, state returns to IDLE. RX bytes are ignored in RUN.
- STEP: o_pipe_enable=1 for exactly one cycle, then return to IDLE. If i_halt=1 in that cycle, o_halted is set.
- o_write and o_pipe_enable are never high in the same cycle.
- o_pipe_enable is never high in LOAD or during the o_pipe_reset pulse.

Test Plan:
- Reset then 'L', bytes 78 56 34 12, EF BE AD DE, FF FF FF FF -> o_pipe_reset pulses once; three writes: 0x12345678@0x0, 0xDEADBEEF@0x4, 0xFFFFFFFF@0x8; o_word_count=3; IDLE afterwards; o_loading low.
- After load, 'R' with i_halt asserted 10 cycles later -> o_pipe_enable high for exactly 10 cycles; o_halted=1; a subsequent 'R' or 'S' is ignored (enable stays 0).
- After load, 'S' x3 -> three isolated one-cycle o_pipe_enable pulses; no writes occur.
- MEM_DEPTH_W=2, load 4 non-halt words -> writes at 0x0, 0x4, 0x8, 0xC; o_overflow=1; IDLE; the 5th word's bytes produce no write.
- i_reset asserted after 2 bytes of a word in LOAD -> no write; all outputs 0. A fresh 'L' plus 4 bytes writes at address 0x0.
- In IDLE, send 0x00 and 0x41 -> no state change, all outputs stay 0. Sending 'L' with a byte landing in the write cycle -> the byte is correctly assembled into the next word.
